// File: rtl/servo_pkg.sv
// Shared types and defaults for the servo move sequencer.
package servo_pkg;

  localparam int DUTY_W = 32;

  localparam int unsigned PERIOD_DEF = 1_000_000;
  localparam int unsigned POS0_DEF   = 50_000;
  localparam int unsigned POS1_DEF   = 75_000;
  localparam int unsigned POS2_DEF   = 100_000;
  localparam int unsigned POS3_DEF   = 125_000;

  typedef enum logic [1:0] {ST_IDLE, ST_RAMP, ST_SETTLE, ST_DONE} st_t;

  typedef logic [DUTY_W-1:0] duty_t;

  typedef struct packed {
    logic [1:0] ch;
    duty_t      target;
  } move_t;

  typedef struct packed {
    duty_t duty;
    logic  hit;
  } step_t;

  // Move cur toward tgt by at most step; never crosses tgt.
  function automatic step_t step_toward(duty_t cur, duty_t tgt, duty_t step);
    step_t r;
    duty_t gap;
    gap   = (tgt >= cur) ? (tgt - cur) : (cur - tgt);
    r.hit = (gap <= step);
    if (r.hit)           r.duty = tgt;
    else if (tgt > cur)  r.duty = cur + step;
    else                 r.duty = cur - step;
    return r;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// PWM frame counter: counts 0..PERIOD-1 and pulses frame_tick on the last count.
module frame_timer
  import servo_pkg::*;
#(
  parameter int unsigned PERIOD = PERIOD_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic frame_tick
);

  localparam duty_t LAST = duty_t'(PERIOD - 1);

  duty_t cnt;

  always_ff @(posedge clk) begin
    if (!reset)           cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + duty_t'(1);
  end

  assign frame_tick = reset && (cnt == LAST);

endmodule

// File: rtl/servo_move_seq.sv
// Servo move sequencer: accepts one move at a time and ramps the chosen channel's
// duty on frame boundaries. Define SERVO_RAMP_EN for STEP-limited ramping;
// otherwise the duty jumps to the target at the first frame tick.
module servo_move_seq
  import servo_pkg::*;
#(
  parameter int          NSERVO        = 4,
  parameter int unsigned PERIOD        = PERIOD_DEF,
  parameter int unsigned POS0          = POS0_DEF,
  parameter int unsigned POS1          = POS1_DEF,
  parameter int unsigned POS2          = POS2_DEF,
  parameter int unsigned POS3          = POS3_DEF,
  parameter int unsigned HOME          = 1,
  parameter int unsigned STEP          = 2_500,
  parameter int unsigned SETTLE_FRAMES = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  input  logic [1:0]               cmd_servo,
  input  logic [1:0]               cmd_pos,
  output logic                     cmd_ready,
  output logic [NSERVO*DUTY_W-1:0] duty,
  output logic [31:0]              period,
  output logic                     frame_tick,
  output logic                     busy,
  output logic                     done
);

  localparam duty_t HOME_DUTY = (HOME == 0) ? duty_t'(POS0) :
                                (HOME == 1) ? duty_t'(POS1) :
                                (HOME == 2) ? duty_t'(POS2) : duty_t'(POS3);

`ifdef SERVO_RAMP_EN
  localparam duty_t STEP_EFF = duty_t'(STEP);
`else
  // A step wider than any gap lands on the target at the first tick.
  localparam duty_t STEP_EFF = duty_t'(STEP) | '1;
`endif

  localparam duty_t SETTLE_LAST = duty_t'(SETTLE_FRAMES - 1);

  function automatic duty_t preset(logic [1:0] idx);
    case (idx)
      2'd0:    return duty_t'(POS0);
      2'd1:    return duty_t'(POS1);
      2'd2:    return duty_t'(POS2);
      default: return duty_t'(POS3);
    endcase
  endfunction

  st_t   state, state_n;
  move_t mv;
  duty_t settle_cnt, settle_n;
  duty_t cur;
  step_t stp;
  logic  accept;
  logic  ramp_we;

  logic [NSERVO-1:0][DUTY_W-1:0] duty_q;

  frame_timer #(.PERIOD(PERIOD)) u_frame_timer (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick)
  );

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign period    = 32'(PERIOD);
  assign accept    = cmd_valid && cmd_ready;
  assign ramp_we   = (state == ST_RAMP) && frame_tick;
  assign duty      = duty_q;

  always_comb begin
    cur = '0;
    for (int k = 0; k < NSERVO; k++)
      if (int'(mv.ch) == k) cur = duty_q[k];
  end

  assign stp = step_toward(cur, mv.target, STEP_EFF);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      mv         <= '0;
      settle_cnt <= '0;
    end else begin
      state      <= state_n;
      settle_cnt <= settle_n;
      if (accept) begin
        mv.ch     <= cmd_servo;
        mv.target <= preset(cmd_pos);
      end
    end
  end

  always_comb begin
    state_n  = state;
    settle_n = settle_cnt;
    case (state)
      ST_IDLE: if (accept) state_n = ST_RAMP;
      ST_RAMP: begin
        if (ramp_we && stp.hit) begin
          state_n  = ST_SETTLE;
          settle_n = '0;
        end
      end
      ST_SETTLE: begin
        if (SETTLE_FRAMES == 0) state_n = ST_DONE;
        else if (frame_tick) begin
          if (settle_cnt == SETTLE_LAST) state_n = ST_DONE;
          else                           settle_n = settle_cnt + duty_t'(1);
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Each lane only takes the ramp result when it is the latched channel.
  for (genvar k = 0; k < NSERVO; k++) begin : g_lane
    duty_t q;
    always_ff @(posedge clk) begin
      if (!reset)                          q <= HOME_DUTY;
      else if (ramp_we && int'(mv.ch) == k) q <= stp.duty;
    end
    assign duty_q[k] = q;
  end

endmodule

// File: tb/tb_servo_move_seq.sv
// Directed bench for servo_move_seq at PERIOD=100, POS=20/30/40/50, STEP=4, SETTLE_FRAMES=2.
module tb_servo_move_seq;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic [1:0]   cmd_servo;
  logic [1:0]   cmd_pos;
  logic         cmd_ready;
  logic [127:0] duty;
  logic [31:0]  period;
  logic         frame_tick;
  logic         busy;
  logic         done;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_seq [8];
  int          exp_n;

  servo_move_seq #(
    .NSERVO(4), .PERIOD(100), .POS0(20), .POS1(30), .POS2(40), .POS3(50),
    .HOME(1), .STEP(4), .SETTLE_FRAMES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_servo  (cmd_servo),
    .cmd_pos    (cmd_pos),
    .cmd_ready  (cmd_ready),
    .duty       (duty),
    .period     (period),
    .frame_tick (frame_tick),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dof(input int k);
    return duty[32*k +: 32];
  endfunction

  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 250);
    if (!frame_tick) chk("tick_timeout", 32'(frame_tick), 1);
  endtask

  task automatic count_to_tick(input string tag, input int want);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 300);
    chk(tag, n, want);
  endtask

  task automatic check_all(input string tag, input logic [31:0] d0, d1, d2, d3);
    chk({tag, "_d0"}, dof(0), d0);
    chk({tag, "_d1"}, dof(1), d1);
    chk({tag, "_d2"}, dof(2), d2);
    chk({tag, "_d3"}, dof(3), d3);
  endtask

  // Full move: expected duty after each ramp tick taken from exp_seq.
  // With poke set, a competing command is held on the bus during the ramp.
  task automatic run_move(input logic [1:0] s, input logic [1:0] p, input bit poke);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_servo = s; cmd_pos = p;
    chk("ready_idle", 32'(cmd_ready), 1);
    @(negedge clk);
    if (poke) begin
      cmd_servo = 2'd3; cmd_pos = 2'd0;
    end else cmd_valid = 1'b0;
    chk("busy_ramp", 32'(busy), 1);
    chk("ready_busy", 32'(cmd_ready), 0);
    for (int i = 0; i < exp_n; i++) begin
      wait_tick();
      @(negedge clk);
      chk($sformatf("ramp_s%0d_%0d", s, i), dof(s), exp_seq[i]);
    end
    cmd_valid = 1'b0;
    wait_tick();
    @(negedge clk);
    chk("settle_no_done", 32'(done), 0);
    wait_tick();
    @(negedge clk);
    chk("done_pulse", 32'(done), 1);
    chk("done_busy", 32'(busy), 1);
    @(negedge clk);
    chk("done_clear", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_servo = '0; cmd_pos = '0;
    repeat (3) @(negedge clk);
    check_all("rst", 30, 30, 30, 30);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_tick", 32'(frame_tick), 0);
    chk("rst_period", period, 100);

    reset = 1'b1;
    count_to_tick("tick_first", 99);
    count_to_tick("tick_gap", 100);
    chk("period_run", period, 100);

`ifdef SERVO_RAMP_EN
    exp_seq[0] = 34; exp_seq[1] = 38; exp_seq[2] = 42; exp_seq[3] = 46; exp_seq[4] = 50; exp_n = 5;
`else
    exp_seq[0] = 50; exp_n = 1;
`endif
    run_move(2'd2, 2'd3, 1'b0);
    check_all("after_s2", 30, 30, 50, 30);

`ifdef SERVO_RAMP_EN
    exp_seq[0] = 26; exp_seq[1] = 22; exp_seq[2] = 20; exp_n = 3;
`else
    exp_seq[0] = 20; exp_n = 1;
`endif
    run_move(2'd0, 2'd0, 1'b1);
    wait_tick();
    @(negedge clk);
    check_all("after_s0", 20, 30, 50, 30);
    chk("no_queue_busy", 32'(busy), 0);

`ifdef SERVO_RAMP_EN
    exp_seq[0] = 34; exp_seq[1] = 38; exp_seq[2] = 40; exp_n = 3;
`else
    exp_seq[0] = 40; exp_n = 1;
`endif
    run_move(2'd1, 2'd2, 1'b0);
    check_all("after_s1", 20, 40, 50, 30);

    @(negedge clk);
    cmd_valid = 1'b1; cmd_servo = 2'd3; cmd_pos = 2'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_tick();
    @(negedge clk);
`ifdef SERVO_RAMP_EN
    chk("mid_s3", dof(3), 34);
`else
    chk("mid_s3", dof(3), 50);
`endif
    reset = 1'b0;
    @(negedge clk);
    check_all("rst_mid", 30, 30, 30, 30);
    chk("rst_mid_ready", 32'(cmd_ready), 1);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_period", period, 100);
    reset = 1'b1;
    count_to_tick("tick_restart", 99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
